// File: rtl/usb_arb_pkg.sv
// -----------------------------------------------------------------------------
// usb_arb_pkg
// Shared definitions for the USB data FIFO write-port arbiter:
//   WORD_W_DEF   default FIFO word width
//   MAX_SRC      largest supported number of producers (index fits in 3 bits)
//   TAG_HEADER   upper byte of the optional per-packet tag word
//   arb_state_t  arbiter state encoding
//   idx_to_onehot  3-bit source index -> MAX_SRC-wide one-hot vector
// -----------------------------------------------------------------------------
package usb_arb_pkg;

   localparam int         WORD_W_DEF = 16;
   localparam int         MAX_SRC    = 8;
   localparam logic [7:0] TAG_HEADER = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TAG     = 2'd1,
      ST_GRANT   = 2'd2,
      ST_RELEASE = 2'd3
   } arb_state_t;

   function automatic logic [MAX_SRC-1:0] idx_to_onehot(input logic [2:0] idx);
      return MAX_SRC'(1) << idx;
   endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// -----------------------------------------------------------------------------
// rr_priority_picker
// Purely combinational round-robin picker: selects the first asserted request
// at or after the pointer, wrapping around modulo N.
// Ports:
//   req     in   N   request vector
//   ptr     in   3   search start position (must be < N)
//   onehot  out  N   one-hot selection (all zero when no request)
//   idx     out  3   index of the selected request
//   any     out  1   at least one request asserted
// -----------------------------------------------------------------------------
module rr_priority_picker
   import usb_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]               req,
   input  logic [$clog2(MAX_SRC)-1:0] ptr,
   output logic [N-1:0]               onehot,
   output logic [$clog2(MAX_SRC)-1:0] idx,
   output logic                       any
);

   localparam int IDX_W = $clog2(MAX_SRC);

   logic [N-1:0]     upper;
   logic [N-1:0]     sel;
   logic [IDX_W-1:0] enc [0:N];

   genvar gi;

   // Requests at or above the pointer have priority; if there are none the
   // search wraps, which is simply the lowest set bit of the full vector.
   generate
      for (gi = 0; gi < N; gi++) begin : g_upper
         assign upper[gi] = req[gi] & (IDX_W'(gi) >= ptr);
      end
   endgenerate

   assign sel    = (|upper) ? upper : req;
   // Isolate the lowest set bit.
   assign onehot = sel & (~sel + 1'b1);

   // One-hot to binary through an OR chain.
   assign enc[0] = '0;
   generate
      for (gi = 0; gi < N; gi++) begin : g_enc
         assign enc[gi+1] = enc[gi] | (onehot[gi] ? IDX_W'(gi) : '0);
      end
   endgenerate

   assign idx = enc[N];
   assign any = |req;

endmodule

// File: rtl/usb_data_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// usb_data_fifo_arbiter
// Shares the single USB data FIFO write port among NUM_SRC producers. Grants
// are packet-atomic (held until the owner drops its request), round-robin fair,
// with per-source back-pressure and an idle-grant watchdog.
//
// Optional feature: define USB_ARB_TAG_EN to prefix each packet with the tag
// word {TAG_HEADER, active_src}; the grant then rises only after the tag has
// been written. Without it the stream is bit-exact source data.
//
// Ports:
//   Clk                   in   1               system clock
//   reset                 in   1               synchronous, active-high
//   src_req               in   NUM_SRC         level request, held for a packet
//   src_wr_en             in   NUM_SRC         write strobes
//   src_din               in   NUM_SRC*WORD_W  write data, source i at [i*WORD_W +: WORD_W]
//   src_grant             out  NUM_SRC         one-hot grant
//   src_full              out  NUM_SRC         FIFO full for the owner, 1 for everyone else
//   usb_data_fifo_wr_en   out  1               FIFO write enable (registered)
//   usb_data_fifo_wr_din  out  WORD_W          FIFO write data (registered)
//   usb_data_fifo_full    in   1               FIFO full
//   active_src            out  3               index of the current owner
//   overflow_flag         out  1               sticky: owner wrote while full
//   timeout_flag          out  1               sticky: watchdog forced a release
//   clear_flags           in   1               clears both sticky flags
// -----------------------------------------------------------------------------
module usb_data_fifo_arbiter
   import usb_arb_pkg::*;
#(
   parameter int NUM_SRC        = 4,
   parameter int WORD_W         = WORD_W_DEF,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                      Clk,
   input  logic                      reset,
   input  logic [NUM_SRC-1:0]        src_req,
   input  logic [NUM_SRC-1:0]        src_wr_en,
   input  logic [NUM_SRC*WORD_W-1:0] src_din,
   output logic [NUM_SRC-1:0]        src_grant,
   output logic [NUM_SRC-1:0]        src_full,
   output logic                      usb_data_fifo_wr_en,
   output logic [WORD_W-1:0]         usb_data_fifo_wr_din,
   input  logic                      usb_data_fifo_full,
   output logic [2:0]                active_src,
   output logic                      overflow_flag,
   output logic                      timeout_flag,
   input  logic                      clear_flags
);

   localparam int             WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   arb_state_t          state_reg;
   logic [NUM_SRC-1:0]  grant_reg;
   logic [2:0]          active_reg;
   logic [2:0]          rr_ptr_reg;
   logic                wr_en_reg;
   logic [WORD_W-1:0]   din_reg;
   logic                overflow_reg;
   logic                timeout_reg;
   logic [WD_W-1:0]     wdog_reg;
`ifdef USB_ARB_TAG_EN
   logic                tag_done_reg;
`endif

   logic [2:0]          ptr_next;
   logic [2:0]          pick_ptr;
   logic [NUM_SRC-1:0]  pick_onehot;
   logic [2:0]          pick_idx;
   logic                pick_any;
   logic                granted_wr;
   logic                granted_req;
   logic                wdog_fire;
   logic [WORD_W-1:0]   din_or [0:NUM_SRC];

   genvar gi;

   // Owner's strobe/data selected by the grant vector; non-owners drop out.
   assign din_or[0] = '0;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         assign din_or[gi+1] = din_or[gi] |
                               (grant_reg[gi] ? src_din[gi*WORD_W +: WORD_W] : '0);
         assign src_full[gi] = grant_reg[gi] ? usb_data_fifo_full : 1'b1;
      end
   endgenerate

   assign granted_wr  = |(grant_reg & src_wr_en);
   assign granted_req = |(grant_reg & src_req);
   assign wdog_fire   = (TIMEOUT_CYCLES != 0) && !granted_wr && (wdog_reg == WD_MAX);

   assign ptr_next = (active_reg == 3'(NUM_SRC - 1)) ? 3'd0 : active_reg + 3'd1;

   // In RELEASE the picker already searches from the updated pointer so the
   // next owner is granted right after the single dead cycle.
   assign pick_ptr = (state_reg == ST_RELEASE) ? ptr_next : rr_ptr_reg;

   rr_priority_picker #(
      .N (NUM_SRC)
   ) u_picker (
      .req    (src_req),
      .ptr    (pick_ptr),
      .onehot (pick_onehot),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         grant_reg    <= '0;
         active_reg   <= '0;
         rr_ptr_reg   <= '0;
         wr_en_reg    <= 1'b0;
         din_reg      <= '0;
         overflow_reg <= 1'b0;
         timeout_reg  <= 1'b0;
         wdog_reg     <= '0;
`ifdef USB_ARB_TAG_EN
         tag_done_reg <= 1'b0;
`endif
      end else begin
         wr_en_reg <= 1'b0;

         // Clear first so a set event later in this block wins.
         if (clear_flags) begin
            overflow_reg <= 1'b0;
            timeout_reg  <= 1'b0;
         end

         case (state_reg)
            ST_IDLE, ST_RELEASE: begin
               if (state_reg == ST_RELEASE) begin
                  rr_ptr_reg <= ptr_next;
               end
               if (pick_any) begin
                  active_reg <= pick_idx;
                  wdog_reg   <= '0;
`ifdef USB_ARB_TAG_EN
                  tag_done_reg <= 1'b0;
                  state_reg    <= ST_TAG;
`else
                  grant_reg  <= pick_onehot;
                  state_reg  <= ST_GRANT;
`endif
               end else begin
                  state_reg <= ST_IDLE;
               end
            end

`ifdef USB_ARB_TAG_EN
            ST_TAG: begin
               // Tag goes out first; the grant follows once it is committed.
               if (tag_done_reg) begin
                  grant_reg <= NUM_SRC'(idx_to_onehot(active_reg));
                  state_reg <= ST_GRANT;
               end else if (!usb_data_fifo_full) begin
                  wr_en_reg    <= 1'b1;
                  din_reg      <= WORD_W'({TAG_HEADER, 5'd0, active_reg});
                  tag_done_reg <= 1'b1;
               end
            end
`endif

            ST_GRANT: begin
               if (granted_wr) begin
                  wdog_reg <= '0;
                  if (usb_data_fifo_full) begin
                     overflow_reg <= 1'b1;
                  end else begin
                     wr_en_reg <= 1'b1;
                     din_reg   <= din_or[NUM_SRC];
                  end
               end else if (TIMEOUT_CYCLES != 0) begin
                  wdog_reg <= wdog_reg + 1'b1;
               end

               // A write in the drop cycle is still forwarded above.
               if (!granted_req) begin
                  grant_reg <= '0;
                  state_reg <= ST_RELEASE;
               end else if (wdog_fire) begin
                  grant_reg   <= '0;
                  timeout_reg <= 1'b1;
                  state_reg   <= ST_RELEASE;
               end
            end

            default: begin
               grant_reg <= '0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign src_grant            = grant_reg;
   assign active_src           = active_reg;
   assign usb_data_fifo_wr_en  = wr_en_reg;
   assign usb_data_fifo_wr_din = din_reg;
   assign overflow_flag        = overflow_reg;
   assign timeout_flag         = timeout_reg;

endmodule

// File: tb/tb_usb_data_fifo_arbiter.sv
// -----------------------------------------------------------------------------
// tb_usb_data_fifo_arbiter
// Directed bench for usb_data_fifo_arbiter (NUM_SRC=4, WORD_W=16,
// TIMEOUT_CYCLES=16). Every word a source writes while owning the port is
// queued with the cycle it must appear on the FIFO port; a separate monitor
// pops and compares whenever the FIFO write enable is seen.
// -----------------------------------------------------------------------------
module tb_usb_data_fifo_arbiter;

   localparam int NS = 4;
   localparam int W  = 16;

   logic          Clk;
   logic          reset;
   logic [NS-1:0] src_req;
   logic [NS-1:0] src_wr_en;
   logic [NS*W-1:0] src_din;
   logic [NS-1:0] src_grant;
   logic [NS-1:0] src_full;
   logic          usb_data_fifo_wr_en;
   logic [W-1:0]  usb_data_fifo_wr_din;
   logic          usb_data_fifo_full;
   logic [2:0]    active_src;
   logic          overflow_flag;
   logic          timeout_flag;
   logic          clear_flags;

   usb_data_fifo_arbiter #(
      .NUM_SRC        (NS),
      .WORD_W         (W),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .Clk                  (Clk),
      .reset                (reset),
      .src_req              (src_req),
      .src_wr_en            (src_wr_en),
      .src_din              (src_din),
      .src_grant            (src_grant),
      .src_full             (src_full),
      .usb_data_fifo_wr_en  (usb_data_fifo_wr_en),
      .usb_data_fifo_wr_din (usb_data_fifo_wr_din),
      .usb_data_fifo_full   (usb_data_fifo_full),
      .active_src           (active_src),
      .overflow_flag        (overflow_flag),
      .timeout_flag         (timeout_flag),
      .clear_flags          (clear_flags)
   );

   typedef struct {
      logic [W-1:0] word;
      int           cyc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   // Monitor: every FIFO write must match the head of the scoreboard in data
   // and in arrival cycle.
   always @(negedge Clk) begin
      exp_t e;
      if (usb_data_fifo_wr_en === 1'b1) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL fifo_write: unexpected word %h at cycle %0d, none required",
                     usb_data_fifo_wr_din, cyc);
         end else begin
            e = exp_q.pop_front();
            if (usb_data_fifo_wr_din !== e.word || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL fifo_write: got %h at cycle %0d, required %h at cycle %0d",
                        usb_data_fifo_wr_din, cyc, e.word, e.cyc);
            end else begin
               $display("fifo write %h at cycle %0d ok", e.word, cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "bench timeout");
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h", nm, act, req);
      end else begin
         $display("check %s = %0h ok", nm, act);
      end
   endtask

   // Source s writes one word this cycle; optionally a non-owner strobes junk.
   task automatic send_word(input int s, input logic [W-1:0] w, input int noise);
      src_wr_en[s]       = 1'b1;
      src_din[s*W +: W]  = w;
      if (noise >= 0) begin
         src_wr_en[noise]      = 1'b1;
         src_din[noise*W +: W] = 16'hDEAD;
      end
      exp_q.push_back('{w, cyc + 1});
      tick();
      src_wr_en = '0;
   endtask

   task automatic wait_grant(input int s, input string nm);
      int n = 0;
      while (src_grant == '0 && n < 8) begin
         tick();
         n++;
      end
      check({nm, "_grant"}, 32'(src_grant), 32'(1 << s));
      check({nm, "_latency"}, 32'(n), 32'd1);
      check({nm, "_active"}, 32'(active_src), 32'(s));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset              = 1'b1;
      src_req            = '0;
      src_wr_en          = '0;
      src_din            = '0;
      usb_data_fifo_full = 1'b0;
      clear_flags        = 1'b0;
      tick();
      tick();
      check("rst_grant",    32'(src_grant), 32'h0);
      check("rst_full",     32'(src_full), 32'hF);
      check("rst_wr_en",    32'(usb_data_fifo_wr_en), 32'h0);
      check("rst_din",      32'(usb_data_fifo_wr_din), 32'h0);
      check("rst_active",   32'(active_src), 32'h0);
      check("rst_flags",    {30'd0, overflow_flag, timeout_flag}, 32'h0);
      reset = 1'b0;
      tick();

`ifdef USB_ARB_TAG_EN
      // Tag word first, grant only after it has been written.
      src_req[3] = 1'b1;
      exp_q.push_back('{16'hA503, cyc + 2});
      tick();
      check("tag_grant_wait1", 32'(src_grant), 32'h0);
      tick();
      check("tag_grant_wait2", 32'(src_grant), 32'h0);
      tick();
      check("tag_grant", 32'(src_grant), 32'h8);
      send_word(3, 16'h7777, -1);
      send_word(3, 16'h8888, -1);
      src_req[3] = 1'b0;
      tick();
      check("tag_drop", 32'(src_grant), 32'h0);
`else
      // ---- single packet from src0 ----
      src_req[0] = 1'b1;
      wait_grant(0, "t1");
      check("t1_full_owner", 32'(src_full), 32'hE);
      send_word(0, 16'h5353, -1);
      send_word(0, 16'h0001, -1);
      send_word(0, 16'hFF45, -1);
      src_req[0] = 1'b0;
      tick();
      check("t1_drop", 32'(src_grant), 32'h0);
      tick();
      check("t1_idle", 32'(src_grant), 32'h0);

      // ---- all four request: order 0,1,2,3,0, one dead cycle ----
      do_reset();
      src_req = 4'hF;
      for (int k = 0; k < 5; k++) begin
         int s;
         s = k % 4;
         wait_grant(s, $sformatf("t2_k%0d", k));
         send_word(s, 16'(16'h1000 * (s + 1) + k * 16), (s + 1) % 4);
         send_word(s, 16'(16'h1000 * (s + 1) + k * 16 + 1), -1);
         src_req[s] = 1'b0;
         tick();
         check($sformatf("t2_k%0d_drop", k), 32'(src_grant), 32'h0);
         if (k == 0) src_req[0] = 1'b1;
      end
      check("t2_no_overflow", 32'(overflow_flag), 32'h0);

      // ---- full handling on src2 ----
      src_req[2] = 1'b1;
      wait_grant(2, "t3");
      send_word(2, 16'hA1A1, -1);
      usb_data_fifo_full = 1'b1;
      #1;
      check("t3_src_full_on", 32'(src_full), 32'hF);
      for (int i = 0; i < 4; i++) tick();
      usb_data_fifo_full = 1'b0;
      #1;
      check("t3_src_full_off", 32'(src_full), 32'hB);
      send_word(2, 16'hB2B2, -1);
      check("t3_obey_no_ovf", 32'(overflow_flag), 32'h0);
      usb_data_fifo_full = 1'b1;
      src_wr_en[2]       = 1'b1;
      src_din[2*W +: W]  = 16'hC3C3;
      tick();
      src_wr_en          = '0;
      usb_data_fifo_full = 1'b0;
      check("t3_ovf_set", 32'(overflow_flag), 32'h1);
      send_word(2, 16'hD4D4, -1);
      check("t3_ovf_sticky", 32'(overflow_flag), 32'h1);
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      check("t3_ovf_clear", 32'(overflow_flag), 32'h0);
      usb_data_fifo_full = 1'b1;
      src_wr_en[2]       = 1'b1;
      src_din[2*W +: W]  = 16'hE5E5;
      clear_flags        = 1'b1;
      tick();
      src_wr_en          = '0;
      usb_data_fifo_full = 1'b0;
      clear_flags        = 1'b0;
      check("t3_set_wins", 32'(overflow_flag), 32'h1);
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      src_req[2]  = 1'b0;
      tick();
      check("t3_drop", 32'(src_grant), 32'h0);

      // ---- watchdog: src2 idles 16 cycles, src3 waiting ----
      src_req[2] = 1'b1;
      wait_grant(2, "t4");
      src_req[3] = 1'b1;
      for (int i = 0; i < 15; i++) tick();
      check("t4_still_granted", 32'(src_grant), 32'h4);
      check("t4_no_timeout_yet", 32'(timeout_flag), 32'h0);
      tick();
      check("t4_grant_dropped", 32'(src_grant), 32'h0);
      check("t4_timeout_set", 32'(timeout_flag), 32'h1);
      tick();
      check("t4_src3_next", 32'(src_grant), 32'h8);
      src_req[3] = 1'b0;
      tick();
      check("t4_src3_drop", 32'(src_grant), 32'h0);
      tick();
      check("t4_src2_requeued", 32'(src_grant), 32'h4);
      src_req[2]  = 1'b0;
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      check("t4_timeout_clear", 32'(timeout_flag), 32'h0);
      tick();

      // ---- reset in the middle of a src1 packet ----
      src_req[1] = 1'b1;
      wait_grant(1, "t5");
      send_word(1, 16'h5A5A, -1);
      src_wr_en[1]      = 1'b1;
      src_din[1*W +: W] = 16'h0BAD;
      reset             = 1'b1;
      tick();
      src_wr_en = '0;
      check("t5_rst_grant", 32'(src_grant), 32'h0);
      check("t5_rst_wr_en", 32'(usb_data_fifo_wr_en), 32'h0);
      check("t5_rst_full", 32'(src_full), 32'hF);
      reset   = 1'b0;
      src_req = 4'b1010;
      wait_grant(1, "t5_after");
      src_req = '0;
      tick();
      check("t5_drop", 32'(src_grant), 32'h0);
`endif

      tick();
      tick();
      check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
